// File: rtl/vp_key_event_tx.sv
// Purpose : merge PS/2 key events and joystick numpad edges into a queued stream of ASCII press/release events for vp_keymap.
// Latency : PS/2 toggle at edge k -> tx_valid_o in the cycle after edge k+1; joystick edges add one cycle (pending mask).
// Backpr. : none upstream; an 8-entry FIFO absorbs bursts, events are dropped (sticky overflow_o) when it is full.
//
// Ports:
//   clk_sys, reset       system clock, asynchronous active-high reset
//   ps2_key[10:0]        [10] toggles per event, [9] pressed, [8] extended (unused), [7:0] set-2 scan code
//   joy_numpad[9:0]      held numpad buttons, bit0..8 = "1".."9", bit9 = "0"
//   tx_valid_o           one-cycle strobe per emitted event
//   tx_ascii_o           event character, held until the next strobe
//   tx_released_o        1 = release event, same timing as tx_ascii_o
//   overflow_o           sticky, set when an event is lost to a full FIFO
//   busy_o               FIFO non-empty or emitter not idle
module vp_key_event_tx #(
    parameter int          FIFO_AW    = 3,
    parameter logic [15:0] GAP_CYCLES = 16'd2000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [9:0]  joy_numpad,
    output logic        tx_valid_o,
    output logic [7:0]  tx_ascii_o,
    output logic        tx_released_o,
    output logic        overflow_o,
    output logic        busy_o
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Capture state
    logic               armed;
    logic               ps2_tog_q;
    logic [9:0]         joy_q;
    logic [9:0]         pend_q;
    logic [9:0]         pend_d;

    // Decode / arbitration
    logic               ps2_hit;
    logic [7:0]         ps2_ascii;
    logic               ps2_req;
    logic [9:0]         joy_tog;
    logic [3:0]         joy_idx;
    logic [7:0]         joy_ascii;
    logic               joy_req;
    logic [9:0]         joy_clr;
    logic               wr_req;
    logic [8:0]         wr_dat;
    logic               wr_en;

    // FIFO
    logic [8:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               pop;
    logic [8:0]         rd_dat;

    // Emitter
    state_t             state_q;
    state_t             state_d;
    logic [15:0]        gap_cnt;

    // Extended-key flag does not change the character produced.
    logic               unused_ext;
    assign unused_ext = ps2_key[8];

    // Set-2 scan code to ASCII.
    always_comb begin
        ps2_hit   = 1'b1;
        ps2_ascii = 8'h00;
        case (ps2_key[7:0])
            8'h16: ps2_ascii = "1";
            8'h1E: ps2_ascii = "2";
            8'h26: ps2_ascii = "3";
            8'h25: ps2_ascii = "4";
            8'h2E: ps2_ascii = "5";
            8'h36: ps2_ascii = "6";
            8'h3D: ps2_ascii = "7";
            8'h3E: ps2_ascii = "8";
            8'h46: ps2_ascii = "9";
            8'h45: ps2_ascii = "0";
            8'h1C: ps2_ascii = "a";
            8'h32: ps2_ascii = "b";
            8'h21: ps2_ascii = "c";
            8'h23: ps2_ascii = "d";
            8'h24: ps2_ascii = "e";
            8'h2B: ps2_ascii = "f";
            8'h34: ps2_ascii = "g";
            8'h33: ps2_ascii = "h";
            8'h43: ps2_ascii = "i";
            8'h3B: ps2_ascii = "j";
            8'h42: ps2_ascii = "k";
            8'h4B: ps2_ascii = "l";
            8'h3A: ps2_ascii = "m";
            8'h31: ps2_ascii = "n";
            8'h44: ps2_ascii = "o";
            8'h4D: ps2_ascii = "p";
            8'h15: ps2_ascii = "q";
            8'h2D: ps2_ascii = "r";
            8'h1B: ps2_ascii = "s";
            8'h2C: ps2_ascii = "t";
            8'h3C: ps2_ascii = "u";
            8'h2A: ps2_ascii = "v";
            8'h1D: ps2_ascii = "w";
            8'h22: ps2_ascii = "x";
            8'h35: ps2_ascii = "y";
            8'h1A: ps2_ascii = "z";
            8'h29: ps2_ascii = " ";
            8'h79: ps2_ascii = "+";
            8'h7B: ps2_ascii = "-";
            8'h7C: ps2_ascii = "*";
            8'h4A: ps2_ascii = "/";
            8'h55: ps2_ascii = "=";
            8'h1F: ps2_ascii = 8'h11;
            8'h27: ps2_ascii = 8'h12;
            8'h5A: ps2_ascii = 8'd10;
            8'h66: ps2_ascii = 8'd8;
            default: ps2_hit = 1'b0;
        endcase
    end

    // Write arbitration: PS/2 wins, otherwise the lowest pending joystick
    // button is serviced. The released flag comes from the live button state,
    // so a button that bounced while pending reports only its final state.
    always_comb begin
        ps2_req = armed && (ps2_key[10] != ps2_tog_q) && ps2_hit;
        joy_tog = armed ? (joy_numpad ^ joy_q) : 10'd0;

        joy_idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (pend_q[i]) joy_idx = 4'(i);
        end
        joy_ascii = (joy_idx == 4'd9) ? 8'h30 : (8'h31 + {4'h0, joy_idx});
        joy_req   = !ps2_req && (pend_q != 10'd0);
        joy_clr   = joy_req ? (10'd1 << joy_idx) : 10'd0;

        // The serviced bit is cleared even if it toggles again this cycle:
        // the entry just written already carries the newest state.
        pend_d = (pend_q | joy_tog) & ~joy_clr;

        wr_req = ps2_req || joy_req;
        wr_dat = ps2_req ? {~ps2_key[9], ps2_ascii}
                         : {~joy_numpad[joy_idx], joy_ascii};
        full   = (count == FULL_CNT);
        wr_en  = wr_req && !full;
        pop    = (state_q == ST_IDLE) && (count != '0);
        rd_dat = fifo_mem[rd_ptr];
    end

    // First clock out of reset only records the baseline so keys held
    // through reset do not produce a press.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            armed     <= 1'b0;
            ps2_tog_q <= 1'b0;
            joy_q     <= 10'd0;
            pend_q    <= 10'd0;
        end else if (!armed) begin
            armed     <= 1'b1;
            ps2_tog_q <= ps2_key[10];
            joy_q     <= joy_numpad;
        end else begin
            ps2_tog_q <= ps2_key[10];
            joy_q     <= joy_numpad;
            pend_q    <= pend_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) fifo_mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_req && full) overflow_o <= 1'b1;
        end
    end

    // Emitter FSM: state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Emitter FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (count != '0) state_d = ST_SEND;
            ST_SEND: state_d = ST_GAP;
            ST_GAP:  if (gap_cnt == 16'd0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Emitter FSM: outputs
    always_comb begin
        tx_valid_o = (state_q == ST_SEND);
        busy_o     = (count != '0) || (state_q != ST_IDLE);
    end

    // Character registers and gap counter
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tx_ascii_o    <= 8'h00;
            tx_released_o <= 1'b0;
            gap_cnt       <= 16'd0;
        end else begin
            if (pop) {tx_released_o, tx_ascii_o} <= rd_dat;
            if (state_q == ST_SEND)
                gap_cnt <= GAP_CYCLES - 16'd1;
            else if (state_q == ST_GAP && gap_cnt != 16'd0)
                gap_cnt <= gap_cnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_vp_key_event_tx.sv
module tb_vp_key_event_tx;

    localparam int G = 40;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] ps2_key = 11'd0;
    logic [9:0]  joy_numpad = 10'd0;
    logic        tx_valid_o;
    logic [7:0]  tx_ascii_o;
    logic        tx_released_o;
    logic        overflow_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    vp_key_event_tx #(.FIFO_AW(3), .GAP_CYCLES(16'(G))) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ps2_key       (ps2_key),
        .joy_numpad    (joy_numpad),
        .tx_valid_o    (tx_valid_o),
        .tx_ascii_o    (tx_ascii_o),
        .tx_released_o (tx_released_o),
        .overflow_o    (overflow_o),
        .busy_o        (busy_o)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc++;

    // Key table: scan code -> character
    logic [7:0] key_code [46] = '{
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h29,
        8'h79, 8'h7B, 8'h7C, 8'h4A, 8'h55, 8'h1F, 8'h27, 8'h5A, 8'h66};
    logic [7:0] key_char [46] = '{
        "1", "2", "3", "4", "5", "6", "7", "8", "9", "0",
        "a", "b", "c", "d", "e", "f", "g", "h", "i", "j",
        "k", "l", "m", "n", "o", "p", "q", "r", "s", "t",
        "u", "v", "w", "x", "y", "z", " ",
        "+", "-", "*", "/", "=", 8'h11, 8'h12, 8'd10, 8'd8};

    function automatic logic [8:0] model_decode(input logic [7:0] code);
        for (int j = 0; j < 46; j++)
            if (key_code[j] == code) return {1'b1, key_char[j]};
        return 9'd0;
    endfunction

    // Reference model: list of expected events {released, ascii} in order.
    logic       m_armed = 1'b0;
    logic       m_tog   = 1'b0;
    logic [9:0] m_joy   = 10'd0;
    logic [9:0] m_pend  = 10'd0;
    logic [8:0] exp_q [$];

    always @(posedge clk_sys) begin
        logic [8:0] d;
        bit         wrote;
        int         sel;
        if (reset) begin
            m_armed = 1'b0;
            m_pend  = 10'd0;
        end else if (!m_armed) begin
            m_armed = 1'b1;
            m_tog   = ps2_key[10];
            m_joy   = joy_numpad;
        end else begin
            wrote = 0;
            d = model_decode(ps2_key[7:0]);
            if (ps2_key[10] != m_tog && d[8]) begin
                exp_q.push_back({~ps2_key[9], d[7:0]});
                wrote = 1;
            end
            sel = -1;
            if (!wrote)
                for (int i = 9; i >= 0; i--) if (m_pend[i]) sel = i;
            m_pend = m_pend | (joy_numpad ^ m_joy);
            if (sel >= 0) begin
                exp_q.push_back({~joy_numpad[sel], (sel == 9) ? 8'h30 : 8'(8'h31 + sel)});
                m_pend[sel] = 1'b0;
            end
            m_tog = ps2_key[10];
            m_joy = joy_numpad;
        end
    end

    // Record every emitted event with its cycle stamp.
    logic [7:0] rec_ascii [$];
    logic       rec_rel   [$];
    int         rec_cyc   [$];

    always @(negedge clk_sys) begin
        if (tx_valid_o) begin
            rec_ascii.push_back(tx_ascii_o);
            rec_rel.push_back(tx_released_o);
            rec_cyc.push_back(cyc);
        end
    end

    task automatic clear_rec();
        rec_ascii.delete();
        rec_rel.delete();
        rec_cyc.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_send(input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
        @(negedge clk_sys);
    endtask

    task automatic wait_rec(input int n, input int budget);
        int k;
        k = 0;
        while (rec_ascii.size() < n && k < budget) begin
            @(negedge clk_sys);
            k++;
        end
        n_checks++;
        if (rec_ascii.size() < n) begin
            n_errors++;
            $display("FAIL wait_rec: got %0d events, required %0d within %0d cycles", rec_ascii.size(), n, budget);
        end
    endtask

    task automatic wait_idle();
        int k;
        tick(3);
        k = 0;
        while (busy_o && k < 20 * (G + 2)) begin
            @(negedge clk_sys);
            k++;
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_idle: busy_o=%b, required 0", busy_o);
        end
        tick(2);
    endtask

    task automatic test_reset();
        ps2_key    = 11'h400;
        joy_numpad = 10'h001;
        tick(2);
        n_checks++;
        if ({tx_valid_o, tx_ascii_o, tx_released_o, overflow_o, busy_o} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b a=%h r=%b o=%b b=%b, required all 0",
                     tx_valid_o, tx_ascii_o, tx_released_o, overflow_o, busy_o);
        end
    endtask

    task automatic test_arming();
        int c;
        clear_rec();
        reset = 1'b0;
        tick(10);
        n_checks++;
        if (rec_ascii.size() != 0 || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL arming_quiet: events=%0d busy=%b, required 0/0", rec_ascii.size(), busy_o);
        end
        c = cyc;
        joy_numpad = 10'h000;
        wait_rec(1, 10);
        if (rec_ascii.size() >= 1) begin
            n_checks++;
            if (rec_ascii[0] !== 8'h31 || rec_rel[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL arming_release: got %h/%b, required 31/1", rec_ascii[0], rec_rel[0]);
            end
            n_checks++;
            if (rec_cyc[0] != c + 3) begin
                n_errors++;
                $display("FAIL joy_latency: got cycle %0d, required %0d", rec_cyc[0], c + 3);
            end
        end
        wait_idle();
    endtask

    task automatic test_ps2_latency();
        int c;
        clear_rec();
        c = cyc;
        ps2_send(8'h1C, 1'b1);
        ps2_send(8'h1C, 1'b0);
        wait_rec(2, 3 * (G + 2));
        if (rec_ascii.size() >= 2) begin
            n_checks++;
            if (rec_cyc[0] != c + 2) begin
                n_errors++;
                $display("FAIL ps2_latency: got cycle %0d, required %0d", rec_cyc[0], c + 2);
            end
            n_checks++;
            if (rec_ascii[0] !== 8'h61 || rec_rel[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL ps2_press: got %h/%b, required 61/0", rec_ascii[0], rec_rel[0]);
            end
            n_checks++;
            if (rec_ascii[1] !== 8'h61 || rec_rel[1] !== 1'b1) begin
                n_errors++;
                $display("FAIL ps2_release: got %h/%b, required 61/1", rec_ascii[1], rec_rel[1]);
            end
            n_checks++;
            if (rec_cyc[1] - rec_cyc[0] < G + 2) begin
                n_errors++;
                $display("FAIL ps2_gap: got spacing %0d, required >= %0d", rec_cyc[1] - rec_cyc[0], G + 2);
            end
        end
        wait_idle();
    endtask

    task automatic test_unknown_code();
        clear_rec();
        ps2_send(8'h07, 1'b1);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (busy_o !== 1'b0) begin
                n_errors++;
                $display("FAIL unknown_busy: busy_o=%b at step %0d, required 0", busy_o, i);
            end
            tick(1);
        end
        n_checks++;
        if (rec_ascii.size() != 0) begin
            n_errors++;
            $display("FAIL unknown_event: got %0d events, required 0", rec_ascii.size());
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] want [3];
        want[0] = "z";
        want[1] = "1";
        want[2] = "0";
        clear_rec();
        joy_numpad = 10'h201;
        ps2_send(8'h1A, 1'b1);
        wait_rec(3, 4 * (G + 2));
        for (int i = 0; i < 3; i++) begin
            if (rec_ascii.size() > i) begin
                n_checks++;
                if (rec_ascii[i] !== want[i] || rec_rel[i] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL simul_order[%0d]: got %h/%b, required %h/0", i, rec_ascii[i], rec_rel[i], want[i]);
                end
            end
        end
        joy_numpad = 10'h000;
        wait_idle();
    endtask

    task automatic test_overflow();
        clear_rec();
        for (int i = 0; i < 10; i++) begin
            ps2_send(key_code[10 + i], 1'b1);
            if (i == 8) begin
                n_checks++;
                if (overflow_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL overflow_early: got %b after 9 events, required 0", overflow_o);
                end
            end
        end
        n_checks++;
        if (overflow_o !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_set: got %b after 10th event, required 1", overflow_o);
        end
        wait_rec(9, 10 * (G + 2));
        tick(2 * (G + 2));
        n_checks++;
        if (rec_ascii.size() != 9) begin
            n_errors++;
            $display("FAIL overflow_count: got %0d events, required 9", rec_ascii.size());
        end
        for (int i = 0; i < 9; i++) begin
            if (rec_ascii.size() > i) begin
                n_checks++;
                if (rec_ascii[i] !== key_char[10 + i]) begin
                    n_errors++;
                    $display("FAIL overflow_order[%0d]: got %h, required %h", i, rec_ascii[i], key_char[10 + i]);
                end
            end
        end
        wait_idle();
        n_checks++;
        if (overflow_o !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_sticky: got %b, required 1", overflow_o);
        end
    endtask

    task automatic test_reset_in_gap();
        clear_rec();
        for (int i = 0; i < 4; i++) ps2_send(key_code[i], 1'b1);
        wait_rec(1, 10);
        tick(5);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL gap_busy: got %b, required 1", busy_o);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({tx_valid_o, tx_ascii_o, tx_released_o, overflow_o, busy_o} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_in_gap: got v=%b a=%h r=%b o=%b b=%b, required all 0",
                     tx_valid_o, tx_ascii_o, tx_released_o, overflow_o, busy_o);
        end
        @(negedge clk_sys);
        tick(2);
        reset = 1'b0;
        clear_rec();
        tick(3 * (G + 2));
        n_checks++;
        if (rec_ascii.size() != 0 || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_quiet: events=%0d busy=%b, required 0/0", rec_ascii.size(), busy_o);
        end
    endtask

    task automatic test_random();
        int n;
        int mode;
        int prev;
        logic [7:0] code;
        clear_rec();
        exp_q.delete();
        for (int b = 0; b < 12; b++) begin
            n = $urandom_range(1, 4);
            for (int e = 0; e < n; e++) begin
                mode = $urandom_range(0, 2);
                if (mode != 1) joy_numpad[$urandom_range(0, 9)] ^= 1'b1;
                if (mode != 0) begin
                    if ($urandom_range(0, 7) == 0) code = 8'h00;
                    else code = key_code[$urandom_range(0, 45)];
                    ps2_send(code, 1'($urandom_range(0, 1)));
                end else begin
                    tick(1);
                end
            end
            wait_idle();
        end
        n_checks++;
        if (rec_ascii.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL random_count: got %0d events, required %0d", rec_ascii.size(), exp_q.size());
        end
        for (int i = 0; i < rec_ascii.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if ({rec_rel[i], rec_ascii[i]} !== exp_q[i]) begin
                n_errors++;
                $display("FAIL random_event[%0d]: got %b/%h, required %b/%h",
                         i, rec_rel[i], rec_ascii[i], exp_q[i][8], exp_q[i][7:0]);
            end
        end
        prev = -1000;
        for (int i = 0; i < rec_cyc.size(); i++) begin
            n_checks++;
            if (rec_cyc[i] - prev < G + 2) begin
                n_errors++;
                $display("FAIL random_spacing[%0d]: got %0d, required >= %0d", i, rec_cyc[i] - prev, G + 2);
            end
            prev = rec_cyc[i];
        end
    endtask

    initial begin
        test_reset();
        test_arming();
        test_ps2_latency();
        test_unknown_code();
        test_simultaneous();
        test_overflow();
        test_reset_in_gap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
